// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared constants, state encoding and PC helpers for the prefetch unit
package ifu_prefetch_pkg;

  localparam logic [63:0] PC_START    = 64'h0000_0000_8000_0000;
  localparam logic [2:0]  RAM_SIZE_DW = 3'b011;
  localparam int          ENTRY_W     = 96;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } ifu_state_e;

  function automatic logic [63:0] word_align(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

  // A fetch starting in the upper word only consumes 4 bytes, so the next fetch is doubleword aligned.
  function automatic logic [63:0] fetch_step(input logic [63:0] pc);
    return pc[2] ? (pc + 64'd4) : (pc + 64'd8);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - instruction queue, two writes and one read per cycle, synchronous clear
module ifu_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_wr0_en,
  input  logic [ENTRY_W-1:0]       i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [ENTRY_W-1:0]       i_wr1_data,
  input  logic                     i_rd_en,
  output logic [ENTRY_W-1:0]       o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [CW-1:0]      r_count;
  logic [1:0]         w_nwr;
  logic [AW-1:0]      w_wp1;

  assign w_nwr = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
  assign w_wp1 = r_wp + AW'(1);

  // Port 1 is only used together with port 0 and lands in the slot right after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_wr0_en) r_mem[r_wp]  <= i_wr0_data;
      if (i_wr1_en) r_mem[w_wp1] <= i_wr1_data;
      r_wp    <= r_wp + AW'(w_nwr);
      r_rp    <= r_rp + AW'(i_rd_en);
      r_count <= r_count + CW'(w_nwr) - CW'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_rp];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit: RAM fetch FSM, redirect handling, instruction queue
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [63:0] PC_RESET = PC_START
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_ram_req_o,
  input  logic        ifu_ram_ready_i,
  output logic [63:0] ifu_ram_addr_o,
  output logic [2:0]  ifu_ram_size_o,
  input  logic [63:0] ifu_ram_data_i,
  input  logic        ifu_ram_valid_i,
  input  logic        hold_i,
  input  logic        jump_i,
  input  logic [63:0] jump_pc_i,
  input  logic        int_cen_i,
  input  logic [63:0] int_addr_i,
  output logic [31:0] ifu_instr_o,
  output logic [63:0] ifu_pc_o,
  output logic        ifu_instr_valid_o,
  input  logic        ifu_instr_ready_i
);

  localparam int            CW       = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FILL_MAX = CW'(QDEPTH - 2);

  ifu_state_e         r_state;
  ifu_state_e         w_state_nxt;
  logic [63:0]        r_fetch_pc;
  logic               w_redir;
  logic [63:0]        w_redir_pc;
  logic               w_push;
  logic               w_wr1_en;
  logic               w_pop;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [ENTRY_W-1:0] w_head;
  logic [ENTRY_W-1:0] w_wr0_data;
  logic [ENTRY_W-1:0] w_wr1_data;

  assign w_redir    = int_cen_i | jump_i;
  assign w_redir_pc = word_align(int_cen_i ? int_addr_i : jump_pc_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Any response that meets a redirect, or arrives while draining, belongs to a stale stream.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!hold_i && !w_redir && (w_count <= FILL_MAX)) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (ifu_ram_ready_i) w_state_nxt = w_redir ? ST_DRAIN : ST_WAIT;
        else if (w_redir)    w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (ifu_ram_valid_i) w_state_nxt = ST_IDLE;
        else if (w_redir)    w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ifu_ram_valid_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_ram_req_o = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      ST_REQ:  ifu_ram_req_o = 1'b1;
      ST_WAIT: w_push        = ifu_ram_valid_i && !w_redir;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_fetch_pc <= PC_RESET;
    else if (w_redir) r_fetch_pc <= w_redir_pc;
    else if (w_push)  r_fetch_pc <= fetch_step(r_fetch_pc);
  end

  assign ifu_ram_addr_o = {r_fetch_pc[63:3], 3'b000};
  assign ifu_ram_size_o = RAM_SIZE_DW;

  assign w_wr0_data = {r_fetch_pc, r_fetch_pc[2] ? ifu_ram_data_i[63:32] : ifu_ram_data_i[31:0]};
  assign w_wr1_en   = w_push && !r_fetch_pc[2];
  assign w_wr1_data = {r_fetch_pc + 64'd4, ifu_ram_data_i[63:32]};

  // Hiding valid during a redirect guarantees nothing pops in the cycle the queue is flushed.
  assign ifu_instr_valid_o = !w_empty && !w_redir;
  assign w_pop             = ifu_instr_valid_o && ifu_instr_ready_i;

  ifu_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_redir),
    .i_wr0_en   (w_push),
    .i_wr0_data (w_wr0_data),
    .i_wr1_en   (w_wr1_en),
    .i_wr1_data (w_wr1_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_head),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  assign ifu_instr_o = w_head[31:0];
  assign ifu_pc_o    = w_head[95:32];

endmodule
